// File: rtl/sqrt_pkg.sv
// Shared constants and FSM state type for the f32 square-root issue/collect stage.
package sqrt_pkg;

  localparam int unsigned F32_WIDTH = 32;
  localparam logic [F32_WIDTH-1:0] F32_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/sync_fifo_tagged.sv
// Count-based synchronous FIFO with combinational head read and synchronous active-low reset.
module sync_fifo_tagged #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 36
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sqrt_issue_ctrl.sv
// Issues buffered f32 operands one at a time to the iterative sqrt core and
// registers each result (with tag and watchdog error flag) on a valid/ready output.
module sqrt_issue_ctrl
  import sqrt_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAGW    = 4,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [F32_WIDTH-1:0] in_data,
  input  logic [TAGW-1:0]      in_tag,
  output logic                 core_start,
  output logic [F32_WIDTH-1:0] core_a,
  input  logic                 core_rdy,
  input  logic [F32_WIDTH-1:0] core_sqrt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [F32_WIDTH-1:0] out_data,
  output logic [TAGW-1:0]      out_tag,
  output logic                 out_err,
  output logic                 busy
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  state_t                 state_q, state_d;
  logic [F32_WIDTH-1:0]   op_data_q, op_data_d;
  logic [TAGW-1:0]        op_tag_q, op_tag_d;
  logic [WDW-1:0]         wd_q, wd_d;
  logic                   out_valid_q, out_valid_d;
  logic [F32_WIDTH-1:0]   out_data_q, out_data_d;
  logic [TAGW-1:0]        out_tag_q, out_tag_d;
  logic                   out_err_q, out_err_d;

  logic                   fifo_pop, fifo_empty, fifo_full;
  logic [TAGW+F32_WIDTH-1:0] fifo_head;

  sync_fifo_tagged #(
    .DEPTH (DEPTH),
    .WIDTH (TAGW + F32_WIDTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (in_valid && in_ready),
    .pop_i   (fifo_pop),
    .wdata_i ({in_tag, in_data}),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign in_ready   = !fifo_full && rst;
  assign core_start = (state_q == ISSUE);
  assign core_a     = op_data_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_tag    = out_tag_q;
  assign out_err    = out_err_q;
  assign busy       = !fifo_empty || (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    op_data_d   = op_data_q;
    op_tag_d    = op_tag_q;
    wd_d        = wd_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_err_d   = out_err_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          op_data_d = fifo_head[F32_WIDTH-1:0];
          op_tag_d  = fifo_head[TAGW+F32_WIDTH-1:F32_WIDTH];
          state_d   = ISSUE;
        end
      end
      // core_rdy may still reflect the previous op here, so it is not sampled.
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = (wd_q == '1) ? wd_q : wd_q + 1'b1;
        if (core_rdy) begin
          out_valid_d = 1'b1;
          out_data_d  = core_sqrt;
          out_tag_d   = op_tag_q;
          out_err_d   = 1'b0;
          state_d     = HOLD;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          out_valid_d = 1'b1;
          out_data_d  = F32_QNAN;
          out_tag_d   = op_tag_q;
          out_err_d   = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            op_data_d = fifo_head[F32_WIDTH-1:0];
            op_tag_d  = fifo_head[TAGW+F32_WIDTH-1:F32_WIDTH];
            state_d   = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_data_q   <= '0;
      op_tag_q    <= '0;
      wd_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_data_q   <= op_data_d;
      op_tag_q    <= op_tag_d;
      wd_q        <= wd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule

// File: tb/tb_sqrt_issue_ctrl.sv
// Directed bench for sqrt_issue_ctrl with a behavioural core stub of programmable latency.
module tb_sqrt_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_tag;
  logic        core_start;
  logic [31:0] core_a;
  logic        core_rdy;
  logic [31:0] core_sqrt;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        out_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  int core_lat   = 3;
  bit core_never = 1'b0;
  int core_cnt;

  always #5 clk = ~clk;

  sqrt_issue_ctrl #(
    .DEPTH   (4),
    .TAGW    (4),
    .TIMEOUT (63)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_tag     (in_tag),
    .core_start (core_start),
    .core_a     (core_a),
    .core_rdy   (core_rdy),
    .core_sqrt  (core_sqrt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_err    (out_err),
    .busy       (busy)
  );

  function automatic logic [31:0] stub_sqrt(input logic [31:0] a);
    case (a)
      32'h3F80_0000: return 32'h3F80_0000;
      32'h4080_0000: return 32'h4000_0000;
      32'h4110_0000: return 32'h4040_0000;
      32'h4180_0000: return 32'h4080_0000;
      32'h41C8_0000: return 32'h40A0_0000;
      32'h4280_0000: return 32'h4100_0000;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  // Core stub: core_start acts as its reset; rdy rises core_lat cycles later and then stays high.
  always @(posedge clk) begin
    if (!rst) begin
      core_cnt  <= 0;
      core_rdy  <= 1'b0;
      core_sqrt <= '0;
    end else if (core_start) begin
      core_cnt <= core_lat;
      core_rdy <= 1'b0;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1 && !core_never) begin
        core_rdy  <= 1'b1;
        core_sqrt <= stub_sqrt(core_a);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] t);
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max && n == 0; i++) begin
      @(negedge clk);
      if (out_valid) n = i;
    end
  endtask

  logic [31:0] b2b_exp [3] = '{32'h4040_0000, 32'h0000_0000, 32'h4080_0000};
  logic [31:0] bp_op   [6] = '{32'h3F80_0000, 32'h4080_0000, 32'h4110_0000,
                               32'h4180_0000, 32'h41C8_0000, 32'h4280_0000};
  logic [31:0] bp_exp  [6] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                               32'h4080_0000, 32'h40A0_0000, 32'h4100_0000};

  initial begin
    int n, got, bad, bubble;
    bit hs_prev, acc;
    logic [31:0] ref_a;

    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_a", core_a, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    // Single op: start two cycles after the push.
    push(32'h4080_0000, 4'd3);
    chk("single_start_t1", core_start, 0);
    @(negedge clk);
    chk("single_start_t2", core_start, 1);
    chk("single_core_a", core_a, 32'h4080_0000);
    @(negedge clk);
    chk("single_start_t3", core_start, 0);
    wait_valid(200, n);
    chk("single_latency", n, 4);
    chk("single_data", out_data, 32'h4000_0000);
    chk("single_tag", out_tag, 3);
    chk("single_err", out_err, 0);
    @(negedge clk);
    chk("single_drop_valid", out_valid, 0);
    chk("single_idle_busy", busy, 0);

    // Back-to-back ops.
    push(32'h4110_0000, 4'd1);
    push(32'h0000_0000, 4'd2);
    push(32'h4180_0000, 4'd3);
    ref_a = core_a;
    chk("b2b_first_core_a", core_a, 32'h4110_0000);
    got = 0; bad = 0; bubble = 0; hs_prev = 1'b0;
    for (int c = 0; c < 300 && got < 3; c++) begin
      @(negedge clk);
      if (core_start) ref_a = core_a;
      else if (!out_valid && core_a !== ref_a) bad++;
      if (hs_prev && !core_start) bubble++;
      hs_prev = 1'b0;
      if (out_valid) begin
        chk("b2b_data", out_data, b2b_exp[got]);
        chk("b2b_tag", out_tag, got + 1);
        got++;
        hs_prev = 1'b1;
      end
    end
    chk("b2b_count", got, 3);
    chk("b2b_core_a_stable", bad, 0);
    chk("b2b_no_idle_bubble", bubble, 0);
    repeat (2) @(negedge clk);

    // Backpressure: fill the FIFO behind the in-flight op.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = bp_op[i]; in_tag = 4'(i);
      @(negedge clk);
      chk("bp_in_ready", in_ready, (i < 4) ? 1 : 0);
    end
    in_data = bp_op[5]; in_tag = 4'd5;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (in_ready !== 1'b0) bad++;
    end
    chk("bp_full_held", bad, 0);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_data", out_data, bp_exp[0]);
    chk("bp_hold_tag", out_tag, 0);
    out_ready = 1'b1;
    got = 1; acc = 1'b0;
    for (int c = 0; c < 400 && got < 6; c++) begin
      @(negedge clk);
      if (acc) in_valid = 1'b0;
      acc = in_valid && in_ready;
      if (out_valid) begin
        chk("bp_data", out_data, bp_exp[got]);
        chk("bp_tag", out_tag, got);
        got++;
      end
    end
    in_valid = 1'b0;
    chk("bp_count", got, 6);
    repeat (2) @(negedge clk);

    // Stale rdy: core_rdy is still high from the last op during ISSUE.
    core_lat = 5;
    push(32'h4080_0000, 4'd7);
    wait_valid(200, n);
    chk("stale_latency", n, 8);
    chk("stale_data", out_data, 32'h4000_0000);
    chk("stale_tag", out_tag, 7);
    chk("stale_err", out_err, 0);
    repeat (2) @(negedge clk);

    // Watchdog with a core that never completes.
    core_never = 1'b1;
    out_ready  = 1'b0;
    push(32'h4080_0000, 4'd6);
    wait_valid(300, n);
    chk("wd_latency", n, 65);
    chk("wd_data", out_data, 32'h7FC0_0000);
    chk("wd_err", out_err, 1);
    chk("wd_tag", out_tag, 6);
    @(negedge clk);
    chk("wd_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("wd_released", out_valid, 0);
    core_never = 1'b0;
    core_lat   = 20;
    @(negedge clk);

    // Reset during WAIT with two ops queued.
    push(32'h4110_0000, 4'd1);
    push(32'h4180_0000, 4'd2);
    push(32'h41C8_0000, 4'd3);
    repeat (2) @(negedge clk);
    chk("rstmid_busy_before", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_in_ready", in_ready, 0);
    chk("rstmid_core_a", core_a, 0);
    @(negedge clk);
    rst = 1'b1;
    core_lat = 3;
    @(negedge clk);
    chk("rstmid_ready_after", in_ready, 1);
    push(32'h41C8_0000, 4'd9);
    wait_valid(200, n);
    chk("rstmid_latency", n, 6);
    chk("rstmid_data", out_data, 32'h40A0_0000);
    chk("rstmid_tag", out_tag, 9);
    chk("rstmid_err", out_err, 0);
    @(negedge clk);
    chk("rstmid_no_stale_ops", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sqrt_issue_ctrl.md
Name: sqrt_issue_ctrl

Overview:
- Upstream issue/collect stage for the iterative f32 square-root core (sqrt32_bit_by_bit via squareroot_f32).
- Buffers operands from the PE datapath on a valid/ready stream and issues one operand at a time to the core.
- Holds the core operand stable while the core iterates, then captures the core result into a valid/ready output register with tag and error flag.
- Includes a watchdog so a hung core cannot stall the PE.

Parameters:
- DEPTH, 4, operand FIFO entries (power of 2, ≥2).
- TAGW, 4, width of the opaque tag carried with each operand.
- TIMEOUT, 63, maximum core cycles before forced completion.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (asserted = 0).
- in_valid  in  1  operand valid.
- in_ready  out  1  FIFO not full.
- in_data  in  32  f32 operand.
- in_tag  in  TAGW  operand tag.
- core_start  out  1  one-cycle active-high start pulse; drives the core's rst pin.
- core_a  out  32  operand to core; stable from the start pulse until capture.
- core_rdy  in  1  core done flag.
- core_sqrt  in  32  core result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_data  out  32  f32 result.
- out_tag  out  TAGW  tag of result.
- out_err  out  1  result forced by watchdog.
- busy  out  1  FIFO non-empty or state ≠ IDLE.

Behaviour:
- Reset (rst = 0 at posedge): FIFO empty, state IDLE, all outputs 0, core_a = 0, watchdog = 0. Reset mid-operation abandons the in-flight op and the FIFO contents. in_ready = 0 during reset.
- FIFO:
  - Push when in_valid & in_ready.
  - in_ready = !full, registered-count based. No bypass, even when full and popping in the same cycle.
  - Simultaneous push and pop are allowed and leave the count unchanged.
  - Pointers wrap modulo DEPTH.
- States: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if FIFO non-empty, pop the head into op_data/op_tag and go to ISSUE.
  - ISSUE: core_start = 1 for exactly this cycle. Watchdog cleared. Next state is WAIT. core_rdy is ignored in ISSUE because it may still show the previous op's completion.
  - WAIT: watchdog increments each cycle.
    - If core_rdy = 1: capture out_data = core_sqrt, out_tag = op_tag, out_err = 0, and go to HOLD.
    - Else if watchdog == TIMEOUT-1: capture out_data = 32'h7FC00000, out_err = 1, and go to HOLD.
    - core_rdy takes precedence when both occur in the same cycle.
  - HOLD: out_valid = 1, outputs stable. When out_ready = 1:
    - FIFO non-empty: pop into op and go to ISSUE (back-to-back, no IDLE bubble).
    - FIFO empty: go to IDLE.
- core_a = op_data, registered. It changes only on a pop, never during ISSUE/WAIT.
- Latency: the operand pushed into an empty, idle block at cycle T produces core_start at T+2. Result latency is 3 cycles plus the core's iteration count.
- out_valid deasserts the cycle after out_ready is accepted, unless the back-to-back rule applies. The next result never appears earlier than 2 cycles later.
- No arithmetic on data. Special values (0, inf, NaN, negatives) are passed through the core unchanged.
- Watchdog width is clog2(TIMEOUT+1) and saturates. It does not wrap.

Decomposition:
- Shared package sqrt_pkg:
  - F32_WIDTH = 32.
  - F32_QNAN = 32'h7FC00000.
  - State encoding localparams IDLE/ISSUE/WAIT/HOLD.
- One sub-module: sync_fifo_tagged (DEPTH × (32+TAGW), synchronous active-low reset). The FSM, watchdog and output register stay in sqrt_issue_ctrl.

Test Plan:
- Single op: push 0x40800000 (4.0), tag 3, with the real core and out_ready = 1. Required response:
  - core_start pulses once, 2 cycles after the push.
  - out_valid is asserted with out_data = 0x40000000, out_tag = 3, out_err = 0.
- Back-to-back: push 0x41100000 (9.0), 0x00000000 and 0x41800000 (16.0) with tags 1, 2, 3. Required response:
  - Results in order: 0x40400000, 0x00000000, 0x40800000, with tags 1, 2, 3.
  - core_a is stable throughout each WAIT.
  - No IDLE cycle occurs between ops.
- Backpressure/full: hold out_ready = 0 and push DEPTH+2 operands. Required response:
  - in_ready drops after DEPTH pushes beyond the in-flight op.
  - No operand is lost.
  - Raising out_ready drains all results in order.
- Watchdog: a stub core that never asserts core_rdy, then push 0x40800000. Required response: after exactly TIMEOUT WAIT cycles, out_valid = 1, out_data = 0x7FC00000, out_err = 1.
- Stale-rdy: a stub core that holds core_rdy = 1 during ISSUE then drops it for 5 cycles. Required response: capture occurs only when core_rdy returns in WAIT, with no premature result.
- Reset mid-op: assert rst = 0 during WAIT with 2 ops queued. Required response:
  - Next cycle: out_valid = 0, busy = 0, in_ready = 0 while rst = 0.
  - After release, a new push completes normally.
